// File: rtl/tube_readout_ctrl.sv
// tube_readout_ctrl: opens a timing window on trigger, freezes and snapshots all tube counts,
// then streams one word per tube over valid/ready before re-clearing the bank.
module tube_readout_ctrl #(
    parameter int NUM_TUBES     = 8,
    parameter int CNT_W         = 9,
    parameter int WINDOW        = 400,
    parameter int CLR_CYCLES    = 2,
    parameter int ZERO_SUPPRESS = 0
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       trigger,
    input  logic [NUM_TUBES*CNT_W-1:0] tube_data,
    output logic                       tube_clr,
    output logic                       gate_enable,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_tube,
    output logic                       out_hit,
    output logic [CNT_W-1:0]           out_count,
    output logic                       busy,
    output logic [7:0]                 missed_trig
);
    localparam int CC_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, WIN, SNAP, READ, CLEAR} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           wc_q, wc_d;
    logic [CC_W-1:0]            cc_q, cc_d;
    logic [NUM_TUBES*CNT_W-1:0] snap_q, snap_d;
    logic                       tube_clr_q, tube_clr_d;
    logic                       gate_q, gate_d;
    logic                       valid_q, valid_d;
    logic [3:0]                 tube_q, tube_d;
    logic                       hit_q, hit_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       busy_q, busy_d;
    logic [7:0]                 missed_q, missed_d;

    // Counts are already frozen during SNAP, so the first word is taken straight from tube_data.
    logic [NUM_TUBES*CNT_W-1:0] src;
    logic [4:0]                 start;
    logic                       found, sel_hit;
    logic [3:0]                 sel;
    logic [CNT_W-1:0]           sel_cnt;

    assign src   = (state_q == SNAP) ? tube_data : snap_q;
    assign start = (state_q == SNAP) ? 5'd0 : {1'b0, tube_q} + 5'd1;

    // Lowest eligible tube index at or above start.
    always_comb begin
        found   = 1'b0;
        sel     = '0;
        sel_hit = 1'b0;
        sel_cnt = '0;
        for (int i = NUM_TUBES - 1; i >= 0; i--) begin
            if (5'(i) >= start && (ZERO_SUPPRESS == 0 || src[i*CNT_W +: CNT_W] < CNT_W'(WINDOW))) begin
                found   = 1'b1;
                sel     = 4'(i);
                sel_cnt = src[i*CNT_W +: CNT_W];
                sel_hit = src[i*CNT_W +: CNT_W] < CNT_W'(WINDOW);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wc_d       = wc_q;
        cc_d       = cc_q;
        snap_d     = snap_q;
        tube_clr_d = tube_clr_q;
        gate_d     = gate_q;
        valid_d    = valid_q;
        tube_d     = tube_q;
        hit_d      = hit_q;
        count_d    = count_q;
        missed_d   = (trigger && state_q != IDLE && missed_q != 8'hFF) ? missed_q + 8'd1 : missed_q;
        case (state_q)
            IDLE: if (trigger) begin
                state_d    = WIN;
                tube_clr_d = 1'b0;
                gate_d     = 1'b1;
                wc_d       = '0;
            end
            WIN: begin
                wc_d = wc_q + 1'b1;
                if (wc_q == CNT_W'(WINDOW - 1)) begin
                    gate_d  = 1'b0;
                    state_d = SNAP;
                end
            end
            SNAP, READ: if (state_q == SNAP || out_ready) begin
                snap_d = src;
                if (found) begin
                    state_d = READ;
                    valid_d = 1'b1;
                    tube_d  = sel;
                    hit_d   = sel_hit;
                    count_d = sel_cnt;
                end else begin
                    state_d    = CLEAR;
                    valid_d    = 1'b0;
                    tube_clr_d = 1'b1;
                    cc_d       = '0;
                end
            end
            CLEAR: if (cc_q == CC_W'(CLR_CYCLES - 1)) state_d = IDLE;
                   else cc_d = cc_q + 1'b1;
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= IDLE;
            wc_q       <= '0;
            cc_q       <= '0;
            snap_q     <= '0;
            tube_clr_q <= 1'b1;
            gate_q     <= 1'b0;
            valid_q    <= 1'b0;
            tube_q     <= '0;
            hit_q      <= 1'b0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            cc_q       <= cc_d;
            snap_q     <= snap_d;
            tube_clr_q <= tube_clr_d;
            gate_q     <= gate_d;
            valid_q    <= valid_d;
            tube_q     <= tube_d;
            hit_q      <= hit_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            missed_q   <= missed_d;
        end
    end

    assign tube_clr    = tube_clr_q;
    assign gate_enable = gate_q;
    assign out_valid   = valid_q;
    assign out_tube    = tube_q;
    assign out_hit     = hit_q;
    assign out_count   = count_q;
    assign busy        = busy_q;
    assign missed_trig = missed_q;
endmodule

// File: tb/tb_tube_readout_ctrl.sv
// tb_tube_readout_ctrl: two instances (plain and zero-suppressed) fed by behavioural tube counters,
// checked against a word scoreboard plus hand-written backpressure, missed-trigger and reset sequences.
module tb_tube_readout_ctrl;
    localparam int WIN = 400;
    localparam int NH  = 511;

    typedef struct packed { logic [3:0] tube; logic hit; logic [8:0] cnt; } word_t;
    typedef struct { bit zs; int hits[8]; int exp_words; int exp_tail; } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic trig_a, trig_b, ready_a, ready_b;
    logic [71:0] data_a, data_b;
    logic clr_a, gate_a, valid_a, hit_a, busy_a;
    logic clr_b, gate_b, valid_b, hit_b, busy_b;
    logic [3:0] tube_a, tube_b;
    logic [8:0] count_a, count_b;
    logic [7:0] missed_a, missed_b;
    logic [8:0] cnt_a [8];
    logic [8:0] cnt_b [8];
    int stop_a [8];
    int stop_b [8];
    word_t exp_a[$], exp_b[$];
    int checks = 0, failures = 0, rx_a = 0, rx_b = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    tube_readout_ctrl #(.ZERO_SUPPRESS(0)) dut (
        .clk(clk), .clr_n(rst_n), .trigger(trig_a), .tube_data(data_a), .tube_clr(clr_a),
        .gate_enable(gate_a), .out_valid(valid_a), .out_ready(ready_a), .out_tube(tube_a),
        .out_hit(hit_a), .out_count(count_a), .busy(busy_a), .missed_trig(missed_a));

    tube_readout_ctrl #(.ZERO_SUPPRESS(1)) dut_zs (
        .clk(clk), .clr_n(rst_n), .trigger(trig_b), .tube_data(data_b), .tube_clr(clr_b),
        .gate_enable(gate_b), .out_valid(valid_b), .out_ready(ready_b), .out_tube(tube_b),
        .out_hit(hit_b), .out_count(count_b), .busy(busy_b), .missed_trig(missed_b));

    // Tube model: counts while gated until its hit time, cleared by tube_clr.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (clr_a) cnt_a[i] <= '0;
            else if (gate_a && int'(cnt_a[i]) < stop_a[i]) cnt_a[i] <= cnt_a[i] + 9'd1;
            if (clr_b) cnt_b[i] <= '0;
            else if (gate_b && int'(cnt_b[i]) < stop_b[i]) cnt_b[i] <= cnt_b[i] + 9'd1;
        end
    end

    always_comb begin
        data_a = '0;
        data_b = '0;
        for (int i = 0; i < 8; i++) begin
            data_a[i*9 +: 9] = cnt_a[i];
            data_b[i*9 +: 9] = cnt_b[i];
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    logic pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;
    word_t pw_a, pw_b;

    always @(negedge clk) begin : mon_a
        word_t w;
        w = '{tube_a, hit_a, count_a};
        if (!rst_n) pv_a = 1'b0;
        else begin
            if (pv_a && !pr_a) begin
                chk("hold_valid_a", longint'(valid_a), 1);
                chk("hold_word_a", longint'(w), longint'(pw_a));
            end
            if (valid_a && ready_a) begin
                rx_a++;
                if (exp_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_word_a: got tube %0d, none expected", tube_a);
                end else chk("word_a", longint'(w), longint'(exp_a.pop_front()));
            end
            pv_a = valid_a; pr_a = ready_a; pw_a = w;
        end
    end

    always @(negedge clk) begin : mon_b
        word_t w;
        w = '{tube_b, hit_b, count_b};
        if (!rst_n) pv_b = 1'b0;
        else begin
            if (pv_b && !pr_b) chk("hold_word_b", longint'(w), longint'(pw_b));
            if (valid_b && ready_b) begin
                rx_b++;
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL extra_word_b: got tube %0d, none expected", tube_b);
                end else chk("word_b", longint'(w), longint'(exp_b.pop_front()));
            end
            pv_b = valid_b; pr_b = ready_b; pw_b = w;
        end
    end

    task automatic load(input vec_t v);
        word_t w;
        for (int i = 0; i < 8; i++) begin
            if (v.zs) stop_b[i] = v.hits[i]; else stop_a[i] = v.hits[i];
            if (!v.zs || v.hits[i] < WIN) begin
                w.tube = 4'(i);
                w.hit  = v.hits[i] < WIN;
                w.cnt  = w.hit ? 9'(v.hits[i]) : 9'(WIN);
                if (v.zs) exp_b.push_back(w); else exp_a.push_back(w);
            end
        end
    endtask

    task automatic pulse(input bit zs);
        @(posedge clk); #2;
        if (zs) trig_b = 1'b1; else trig_a = 1'b1;
        @(posedge clk); #2;
        trig_a = 1'b0; trig_b = 1'b0;
    endtask

    task automatic run_event(input vec_t v, input string name);
        int gate_n, clr_cnt, tail, rx0, cyc;
        load(v);
        rx0 = v.zs ? rx_b : rx_a;
        pulse(v.zs);
        gate_n = 0; clr_cnt = 0; tail = 0; cyc = 0;
        while ((v.zs ? busy_b : busy_a) && cyc < 3000) begin
            if (v.zs ? gate_b : gate_a) gate_n++;
            else if (gate_n > 0) tail++;
            if (v.zs ? clr_b : clr_a) clr_cnt++;
            @(posedge clk); #2;
            cyc++;
        end
        chk({name, "_done"}, longint'(cyc < 3000), 1);
        chk({name, "_gate_cycles"}, gate_n, WIN);
        chk({name, "_clear_cycles"}, clr_cnt, 2);
        chk({name, "_tail_cycles"}, tail, v.exp_tail);
        chk({name, "_words"}, (v.zs ? rx_b : rx_a) - rx0, v.exp_words);
        chk({name, "_queue_empty"}, v.zs ? exp_b.size() : exp_a.size(), 0);
    endtask

    initial begin
        vec_t bp;
        int c, rx0;
        vecs[0] = '{0, '{NH, NH, NH, 120, NH, NH, NH, NH}, 8, 11};
        vecs[1] = '{0, '{0, NH, NH, NH, 1, NH, NH, 399}, 8, 11};
        vecs[2] = '{0, '{10, 20, 30, 40, 50, 60, 70, 80}, 8, 11};
        vecs[3] = '{1, '{NH, 5, NH, NH, NH, NH, 399, NH}, 2, 5};
        vecs[4] = '{1, '{NH, NH, NH, NH, NH, NH, NH, NH}, 0, 3};
        vecs[5] = '{1, '{0, NH, NH, NH, NH, NH, NH, 399}, 2, 5};
        rst_n = 1'b0; trig_a = 1'b0; trig_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        for (int i = 0; i < 8; i++) begin stop_a[i] = NH; stop_b[i] = NH; end
        repeat (6) begin @(posedge clk); #2; trig_a = ~trig_a; trig_b = ~trig_b; end
        chk("rst_tube_clr", longint'(clr_a), 1);
        chk("rst_gate", longint'(gate_a), 0);
        chk("rst_valid", longint'(valid_a), 0);
        chk("rst_busy", longint'(busy_a), 0);
        chk("rst_missed", longint'(missed_a), 0);
        chk("rst_tube_count", longint'({tube_a, count_a}), 0);
        chk("rst_zs_busy_missed", longint'({busy_b, missed_b}), 0);
        trig_a = 1'b0; trig_b = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 6; k++) run_event(vecs[k], $sformatf("vec%0d", k));
        // Backpressure: stall word 2 for five cycles, which stretches the tail by five.
        bp = vecs[0];
        bp.exp_tail = 16;
        fork
            run_event(bp, "backpressure");
            begin
                c = 0;
                while (!(valid_a && tube_a == 4'd2) && c < 1000) begin @(posedge clk); #2; c++; end
                chk("bp_reach_word2", longint'(c < 1000), 1);
                ready_a = 1'b0;
                repeat (5) begin @(posedge clk); #2; end
                ready_a = 1'b1;
            end
        join
        // Missed triggers: hold readout stalled while 300 triggers arrive.
        load(vecs[0]);
        rx0 = rx_a;
        ready_a = 1'b0;
        pulse(1'b0);
        c = 0;
        while (!valid_a && c < 1000) begin @(posedge clk); #2; c++; end
        chk("missed_reach_readout", longint'(c < 1000), 1);
        repeat (300) pulse(1'b0);
        chk("missed_saturated", longint'(missed_a), 255);
        chk("missed_still_busy", longint'(busy_a), 1);
        ready_a = 1'b1;
        c = 0;
        while (busy_a && c < 1000) begin @(posedge clk); #2; c++; end
        chk("missed_done", longint'(c < 1000), 1);
        chk("missed_words", rx_a - rx0, 8);
        repeat (20) @(posedge clk);
        #2;
        chk("missed_no_extra_event", longint'(busy_a), 0);
        chk("missed_queue_empty", exp_a.size(), 0);
        // Reset mid-readout, right after word 3 is accepted.
        load(vecs[2]);
        pulse(1'b0);
        c = 0;
        while (!(valid_a && tube_a == 4'd4) && c < 1000) begin @(posedge clk); #2; c++; end
        chk("rstmid_reach_word4", longint'(c < 1000), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", longint'(valid_a), 0);
        chk("rstmid_tube_clr", longint'(clr_a), 1);
        chk("rstmid_busy_gate", longint'({busy_a, gate_a}), 0);
        chk("rstmid_missed", longint'(missed_a), 0);
        exp_a.delete();
        repeat (3) @(posedge clk);
        #2; rst_n = 1'b1;
        run_event(vecs[0], "after_reset");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
